// File: rtl/alu_div_iter_pkg.sv
// Shared constants for the iterative divider: datapath width, FSM encodings and W-op helpers.
// Optional build macro ALU_DIV_W_SHORT_EN is consumed by alu_div_iter.
package alu_div_iter_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned DIV_ITER_W = 7;

    localparam logic [1:0] DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] DIV_ST_CALC = 2'd1;
    localparam logic [1:0] DIV_ST_FIX  = 2'd2;
    localparam logic [1:0] DIV_ST_DONE = 2'd3;

    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-32){1'b1}}, 1'b1, {31{1'b0}}};

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        return {{(XLEN-32){x[31]}}, x[31:0]};
    endfunction

    // W ops see only bits [31:0], extended according to signedness.
    function automatic logic [XLEN-1:0] narrow(input logic [XLEN-1:0] x,
                                               input logic is_w,
                                               input logic is_signed);
        if (!is_w)
            return x;
        return is_signed ? sext_w(x) : {{(XLEN-32){1'b0}}, x[31:0]};
    endfunction

endpackage

// File: rtl/alu_div_iter_if.sv
// Execute-stage divide request/response bundle; master = execute, slave = divider.
interface alu_div_iter_if import alu_div_iter_pkg::*; ();

    logic            flush_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic            is_signed_i;
    logic            is_w_i;
    logic            is_rem_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_data_o;

    modport master (
        output flush_i, req_valid_i, is_signed_i, is_w_i, is_rem_i,
               dividend_i, divisor_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport slave (
        input  flush_i, req_valid_i, is_signed_i, is_w_i, is_rem_i,
               dividend_i, divisor_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );

endinterface

// File: rtl/alu_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module alu_div_step import alu_div_iter_pkg::*; (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nx,
    output logic [XLEN-1:0] quot_nx
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] trial;

    // rem < divisor always holds, so bit XLEN of the trial difference is a clean borrow.
    always_comb begin
        rem_sh = {rem, quot[XLEN-1]};
        trial  = rem_sh - {1'b0, divisor};
        if (trial[XLEN]) begin
            rem_nx  = rem_sh[XLEN-1:0];
            quot_nx = {quot[XLEN-2:0], 1'b0};
        end else begin
            rem_nx  = trial[XLEN-1:0];
            quot_nx = {quot[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/alu_div_iter.sv
// Multi-cycle restoring divider (RISC-V M DIV/REM and W forms) answering execute-stage requests.
// Build macro ALU_DIV_W_SHORT_EN: W ops iterate 32 times instead of XLEN.
module alu_div_iter import alu_div_iter_pkg::*; (
    input logic           clk,
    input logic           rst,
    alu_div_iter_if.slave bus
);

    logic [1:0]            state;
    logic [DIV_ITER_W-1:0] count;
    logic [XLEN-1:0]       rem_q, quot_q, divisor_q, rsp_data_q;
    logic                  is_rem_q, is_w_q, neg_q_q, neg_r_q;

    logic [XLEN-1:0]       a_n, b_n, a_mag, b_mag, quot_init, special_res;
    logic [XLEN-1:0]       rem_nx, quot_nx, q_s, r_s, sel_res, fix_res;
    logic [DIV_ITER_W-1:0] cnt_init;
    logic                  a_neg, b_neg, div_zero, ovf;

    always_comb begin
        a_n      = narrow(bus.dividend_i, bus.is_w_i, bus.is_signed_i);
        b_n      = narrow(bus.divisor_i, bus.is_w_i, bus.is_signed_i);
        a_neg    = bus.is_signed_i & a_n[XLEN-1];
        b_neg    = bus.is_signed_i & b_n[XLEN-1];
        a_mag    = a_neg ? (~a_n + 1'b1) : a_n;
        b_mag    = b_neg ? (~b_n + 1'b1) : b_n;
        div_zero = (b_n == '0);
        ovf      = bus.is_signed_i & (b_n == '1) &
                   (a_n == (bus.is_w_i ? MIN_W : MIN_X));
        if (div_zero)
            special_res = bus.is_rem_i ? a_n : '1;
        else
            special_res = bus.is_rem_i ? '0 : a_n;
        if (bus.is_w_i)
            special_res = sext_w(special_res);
`ifdef ALU_DIV_W_SHORT_EN
        // W magnitudes fit in 32 bits: pre-shift so only 32 steps are needed.
        quot_init = bus.is_w_i ? (a_mag << 32) : a_mag;
        cnt_init  = bus.is_w_i ? DIV_ITER_W'(31) : DIV_ITER_W'(XLEN-1);
`else
        quot_init = a_mag;
        cnt_init  = DIV_ITER_W'(XLEN-1);
`endif
    end

    alu_div_step u_step (
        .rem     (rem_q),
        .quot    (quot_q),
        .divisor (divisor_q),
        .rem_nx  (rem_nx),
        .quot_nx (quot_nx)
    );

    always_comb begin
        q_s     = neg_q_q ? (~quot_q + 1'b1) : quot_q;
        r_s     = neg_r_q ? (~rem_q + 1'b1) : rem_q;
        sel_res = is_rem_q ? r_s : q_s;
        fix_res = is_w_q ? sext_w(sel_res) : sel_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DIV_ST_IDLE;
            count      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            rsp_data_q <= '0;
            is_rem_q   <= 1'b0;
            is_w_q     <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
        end else if (bus.flush_i) begin
            state <= DIV_ST_IDLE;
        end else begin
            case (state)
                DIV_ST_IDLE: if (bus.req_valid_i) begin
                    is_rem_q <= bus.is_rem_i;
                    is_w_q   <= bus.is_w_i;
                    neg_q_q  <= a_neg ^ b_neg;
                    neg_r_q  <= a_neg;
                    if (div_zero || ovf) begin
                        rsp_data_q <= special_res;
                        state      <= DIV_ST_DONE;
                    end else begin
                        rem_q     <= '0;
                        quot_q    <= quot_init;
                        divisor_q <= b_mag;
                        count     <= cnt_init;
                        state     <= DIV_ST_CALC;
                    end
                end
                DIV_ST_CALC: begin
                    rem_q  <= rem_nx;
                    quot_q <= quot_nx;
                    if (count == '0)
                        state <= DIV_ST_FIX;
                    else
                        count <= count - 1'b1;
                end
                DIV_ST_FIX: begin
                    rsp_data_q <= fix_res;
                    state      <= DIV_ST_DONE;
                end
                DIV_ST_DONE: if (bus.rsp_ready_i) state <= DIV_ST_IDLE;
                default: state <= DIV_ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = (state == DIV_ST_IDLE);
    assign bus.rsp_valid_o = (state == DIV_ST_DONE);
    assign bus.rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_alu_div_iter.sv
// Randomized self-checking bench for alu_div_iter against an arithmetic RISC-V M reference.
module tb_alu_div_iter;
    import alu_div_iter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_div_iter_if bus ();

    alu_div_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference built directly from RISC-V M rules using SV integer division.
    function automatic logic [63:0] model(input bit s, input bit w, input bit r,
                                          input logic [63:0] a, input logic [63:0] b,
                                          output bit special);
        logic [31:0] a32, b32, q32, r32, res32;
        logic [63:0] q64, r64;
        longint      sa, sb;
        int          sa32, sb32;
        special = 1'b0;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            sa32 = $signed(a32);
            sb32 = $signed(b32);
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; special = 1'b1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; special = 1'b1;
            end else if (s) begin
                q32 = 32'(sa32 / sb32); r32 = 32'(sa32 % sb32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            res32 = r ? r32 : q32;
            return {{32{res32[31]}}, res32};
        end
        sa = $signed(a);
        sb = $signed(b);
        if (b == 64'd0) begin
            q64 = '1; r64 = a; special = 1'b1;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a; r64 = 64'd0; special = 1'b1;
        end else if (s) begin
            q64 = 64'(sa / sb); r64 = 64'(sa % sb);
        end else begin
            q64 = a / b; r64 = a % b;
        end
        return r ? r64 : q64;
    endfunction

    task automatic drive_req(input bit s, input bit w, input bit r,
                             input logic [63:0] a, input logic [63:0] b);
        bus.is_signed_i = s;
        bus.is_w_i      = w;
        bus.is_rem_i    = r;
        bus.dividend_i  = a;
        bus.divisor_i   = b;
        bus.req_valid_i = 1'b1;
    endtask

    task automatic scramble_inputs();
        bus.req_valid_i = 1'b0;
        bus.dividend_i  = {$urandom, $urandom};
        bus.divisor_i   = {$urandom, $urandom};
        bus.is_signed_i = 1'($urandom);
        bus.is_w_i      = 1'($urandom);
        bus.is_rem_i    = 1'($urandom);
    endtask

    task automatic run_op(input string tag, input bit s, input bit w, input bit r,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] exp;
        bit          sp;
        int          lat, exp_lat;
        exp = model(s, w, r, a, b, sp);
`ifdef ALU_DIV_W_SHORT_EN
        exp_lat = sp ? 1 : (w ? 34 : 66);
`else
        exp_lat = sp ? 1 : 66;
`endif
        @(negedge clk);
        check({tag, "/req_ready"}, 64'(bus.req_ready_o), 64'd1);
        drive_req(s, w, r, a, b);
        @(posedge clk);
        #1;
        scramble_inputs();
        lat = 1;
        while (!bus.rsp_valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/data"}, bus.rsp_data_o, exp);
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "/hold_data"}, bus.rsp_data_o, exp);
            check({tag, "/hold_busy"}, {62'd0, bus.rsp_valid_o, bus.req_ready_o}, 64'b10);
        end
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b0;
        check({tag, "/released"}, {62'd0, bus.rsp_valid_o, bus.req_ready_o}, 64'b01);
    endtask

    initial begin
        logic [63:0] ra, rb;
        bit          rs, rw, rr;
        int          seen;

        rst             = 1'b1;
        bus.flush_i     = 1'b0;
        bus.rsp_ready_i = 1'b0;
        scramble_inputs();
        #12;
        check("reset_ready", 64'(bus.req_ready_o), 64'd1);
        check("reset_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("reset_data", bus.rsp_data_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_100_7", 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 0);
        run_op("remu_100_7", 1'b0, 1'b0, 1'b1, 64'd100, 64'd7, 0);
        run_op("div_m7_2", 1'b1, 1'b0, 1'b0, -64'sd7, 64'd2, 0);
        run_op("rem_m7_2", 1'b1, 1'b0, 1'b1, -64'sd7, 64'd2, 0);
        run_op("divu_by0", 1'b0, 1'b0, 1'b0, 64'd5, 64'd0, 0);
        run_op("remu_by0", 1'b0, 1'b0, 1'b1, 64'd5, 64'd0, 0);
        run_op("div_ovf", 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        run_op("rem_ovf", 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, '1, 0);
        run_op("divw_ovf", 1'b1, 1'b1, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 0);
        run_op("divuw_hi", 1'b0, 1'b1, 1'b0, 64'h1_0000_000A, 64'd3, 0);
        run_op("remw_neg", 1'b1, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0);
        run_op("hold5", 1'b1, 1'b0, 1'b0, 64'd12345678, -64'sd91, 5);

        // Flush during CALC: no response, then a fresh request completes.
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3);
        @(posedge clk);
        #1;
        scramble_inputs();
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush_state", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, 64'b01);
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid_o) seen++;
        end
        check("flush_no_rsp", 64'(seen), 64'd0);
        run_op("after_flush", 1'b0, 1'b0, 1'b1, 64'd1000, 64'd3, 0);

        // Flush wins over a same-cycle request.
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, 64'd9, 64'd0);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        scramble_inputs();
        check("flush_vs_accept", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, 64'b01);

        // Asynchronous reset mid-operation clears state without a clock edge.
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b0, 64'd777, 64'd5);
        @(posedge clk);
        #1;
        scramble_inputs();
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, 64'b01);
        check("arst_data", bus.rsp_data_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int unsigned n = 0; n < 30; n++) begin
            rs = 1'($urandom);
            rw = 1'($urandom);
            rr = 1'($urandom);
            ra = {$urandom, $urandom} >> $urandom_range(40, 0);
            rb = {$urandom, $urandom} >> $urandom_range(63, 0);
            if ($urandom_range(1, 0) == 1) ra = -ra;
            case ($urandom_range(9, 0))
                0: rb = {$urandom, 32'd0};
                1: begin
                    rs = 1'b1;
                    ra = rw ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    rb = '1;
                end
                2: rb = -({32'd0, $urandom} >> $urandom_range(31, 0));
                default: ;
            endcase
            run_op($sformatf("rand%0d", n), rs, rw, rr, ra, rb, int'($urandom_range(2, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
